edge_detection: RTL and testbench

EDGE_DETECTION -- requirements
Module: edge_detection

---
 rtl/edge_det_pkg.sv | 28 ++
 rtl/edge_bit_buffer.sv | 33 +++
 rtl/edge_detection.sv | 117 +++++++++++
 tb/tb_edge_detection.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/edge_det_pkg.sv
// Shared encodings, default geometry and the edge-decision helper for the edge detector.
package edge_det_pkg;

    typedef enum logic [2:0] {
        SCAN_ROW = 3'b000,
        SCAN_COL = 3'b001
    } scan_mode_e;

    typedef enum logic {
        PHASE_WRITE = 1'b0,
        PHASE_READ  = 1'b1
    } phase_e;

    localparam int DEF_IMG_W     = 64;
    localparam int DEF_IMG_H     = 64;
    localparam int DEF_THRESHOLD = 20;

    // Strictly greater than threshold, using a 9-bit signed difference so no wrap occurs.
    function automatic logic is_edge(input logic [7:0] cur, input logic [7:0] prev,
                                     input logic [7:0] th);
        logic signed [8:0] diff;
        logic [8:0]        mag;
        diff = $signed({1'b0, cur}) - $signed({1'b0, prev});
        mag  = diff[8] ? 9'(-diff) : 9'(diff);
        return mag > {1'b0, th};
    endfunction

endpackage

// File: rtl/edge_bit_buffer.sv
// N x 1 edge-bit store: one write port, one registered read port (only the read register resets).
module edge_bit_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          clr,
    output logic          rdata
);

    logic mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rdata <= 1'b0;
        else if (clr)
            rdata <= 1'b0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/edge_detection.sv
// Streaming horizontal edge detector with a bit-map buffer and a row-major read-out phase.
// Optional 2-tap input smoothing is enabled by defining EDGE_DET_SMOOTH_EN.
module edge_detection
    import edge_det_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int THRESHOLD = DEF_THRESHOLD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       resetBuff,
    input  logic       enb,
    input  logic       modeBuffer,
    input  logic [2:0] modeCounter,
    input  logic [7:0] In_Arrary,
    output logic       Edges,
    output logic       complete
);

    localparam int N  = IMG_W * IMG_H;
    localparam int CW = $clog2(N + 1);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] N_CNT = CW'(N);
    localparam logic [CW-1:0] W_CNT = CW'(IMG_W);
    localparam logic [CW-1:0] H_CNT = CW'(IMG_H);
    localparam logic [7:0]    TH8   = 8'(THRESHOLD);

    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] col_row;
    logic [CW-1:0] col_idx;
    logic [CW-1:0] line_pos;
    logic [7:0]    prev_pix;
    logic [7:0]    cmp_pix;
    logic [AW-1:0] wr_addr;
    logic          col_mode;
    logic          line_start;
    logic          edge_bit;
    logic          wr_en;
    logic          rd_en;

`ifdef EDGE_DET_SMOOTH_EN
    logic [7:0] prev_raw;
    logic [8:0] smooth_sum;
`endif

    // Column mode transposes the incoming stream so the buffer always holds a row-major map.
    always_comb begin
        col_mode   = (modeCounter == SCAN_COL);
        col_row    = wr_cnt % H_CNT;
        col_idx    = wr_cnt / H_CNT;
        line_pos   = col_mode ? col_row : (wr_cnt % W_CNT);
        line_start = (line_pos == '0);
        wr_addr    = col_mode ? AW'(col_row * W_CNT + col_idx) : AW'(wr_cnt);
`ifdef EDGE_DET_SMOOTH_EN
        smooth_sum = {1'b0, In_Arrary} + {1'b0, (line_start ? 8'd0 : prev_raw)};
        cmp_pix    = 8'(smooth_sum >> 1);
`else
        cmp_pix    = In_Arrary;
`endif
        edge_bit   = !line_start && is_edge(cmp_pix, prev_pix, TH8);
        wr_en      = enb && !resetBuff && (modeBuffer == PHASE_WRITE) && (wr_cnt < N_CNT);
        rd_en      = enb && !resetBuff && (modeBuffer == PHASE_READ) && (rd_cnt < N_CNT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            prev_pix <= '0;
            complete <= 1'b0;
        end else if (resetBuff) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            prev_pix <= '0;
            complete <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_cnt   <= wr_cnt + 1'b1;
                prev_pix <= cmp_pix;
            end
            if (rd_en)
                rd_cnt <= rd_cnt + 1'b1;
            else if (enb && (modeBuffer == PHASE_READ) && (rd_cnt == N_CNT))
                complete <= 1'b1;
        end
    end

`ifdef EDGE_DET_SMOOTH_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            prev_raw <= '0;
        else if (resetBuff)
            prev_raw <= '0;
        else if (wr_en)
            prev_raw <= In_Arrary;
    end
`endif

    edge_bit_buffer #(
        .DEPTH(N),
        .AW   (AW)
    ) u_buf (
        .clk  (clk),
        .reset(reset),
        .we   (wr_en),
        .waddr(wr_addr),
        .wdata(edge_bit),
        .re   (rd_en),
        .raddr(AW'(rd_cnt)),
        .clr  (resetBuff),
        .rdata(Edges)
    );

endmodule

// File: tb/tb_edge_detection.sv
// Directed bench for edge_detection on a 4x4 image with threshold 20.
module tb_edge_detection;
    import edge_det_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int TH = 20;
    localparam int N  = W * H;

    logic       clk;
    logic       reset;
    logic       resetBuff;
    logic       enb;
    logic       modeBuffer;
    logic [2:0] modeCounter;
    logic [7:0] In_Arrary;
    logic       Edges;
    logic       complete;

    int checkCount = 0;
    int passCount  = 0;

    // Rows: plain step, threshold boundary (20 vs 21), line-start suppression, falling step.
    logic [7:0] rowPix [N] = '{8'd0, 8'd0, 8'd100, 8'd100,
                               8'd10, 8'd30, 8'd51, 8'd51,
                               8'd0, 8'd0, 8'd100, 8'd100,
                               8'd0, 8'd100, 8'd100, 8'd0};
    logic [7:0] stepPix [N] = '{8'd0, 8'd0, 8'd100, 8'd100,
                                8'd0, 8'd0, 8'd100, 8'd100,
                                8'd0, 8'd0, 8'd100, 8'd100,
                                8'd0, 8'd0, 8'd100, 8'd100};
`ifdef EDGE_DET_SMOOTH_EN
    logic rowExp  [N] = '{0,0,1,1, 0,0,0,0, 0,0,1,1, 0,1,1,1};
    logic colExp  [N] = '{0,0,0,0, 0,0,0,0, 1,1,1,1, 1,1,1,1};
    logic stepExp [N] = '{0,0,1,1, 0,0,1,1, 0,0,1,1, 0,0,1,1};
`else
    logic rowExp  [N] = '{0,0,1,0, 0,0,1,0, 0,0,1,0, 0,1,0,1};
    logic colExp  [N] = '{0,0,0,0, 0,0,0,0, 1,1,1,1, 0,0,0,0};
    logic stepExp [N] = '{0,0,1,0, 0,0,1,0, 0,0,1,0, 0,0,1,0};
`endif

    edge_detection #(
        .IMG_W    (W),
        .IMG_H    (H),
        .THRESHOLD(TH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .resetBuff  (resetBuff),
        .enb        (enb),
        .modeBuffer (modeBuffer),
        .modeCounter(modeCounter),
        .In_Arrary  (In_Arrary),
        .Edges      (Edges),
        .complete   (complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic e, input logic mb, input logic [2:0] mc,
                                 input logic [7:0] pix, input logic rb);
        enb         = e;
        modeBuffer  = mb;
        modeCounter = mc;
        In_Arrary   = pix;
        resetBuff   = rb;
        @(posedge clk);
        #1;
    endtask

    task automatic writeImage(input logic [7:0] pix [N], input logic [2:0] mc);
        for (int i = 0; i < N; i++)
            applyStimulus(1'b1, PHASE_READ == 1'b1 ? 1'b0 : 1'b1, mc, pix[i], 1'b0);
    endtask

    task automatic readRange(input string name, input logic exp [N], input int first,
                             input int last);
        for (int i = first; i <= last; i++) begin
            applyStimulus(1'b1, 1'b1, SCAN_ROW, 8'd0, 1'b0);
            checkOutput($sformatf("%s bit%0d", name, i), Edges, exp[i]);
            checkOutput($sformatf("%s complete@%0d", name, i), complete, 1'b0);
        end
    endtask

    initial begin
        reset       = 1'b0;
        resetBuff   = 1'b0;
        enb         = 1'b0;
        modeBuffer  = 1'b0;
        modeCounter = SCAN_ROW;
        In_Arrary   = 8'd0;
        #1;
        checkOutput("reset Edges", Edges, 1'b0);
        checkOutput("reset complete", complete, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Row-major image, plus one surplus pixel that must be ignored.
        writeImage(rowPix, SCAN_ROW);
        applyStimulus(1'b1, 1'b0, SCAN_ROW, 8'd255, 1'b0);
        readRange("row", rowExp, 0, 7);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, SCAN_ROW, 8'd0, 1'b0);
            checkOutput($sformatf("hold Edges %0d", k), Edges, rowExp[7]);
            checkOutput($sformatf("hold complete %0d", k), complete, 1'b0);
        end
        readRange("row", rowExp, 8, 15);
        applyStimulus(1'b1, 1'b1, SCAN_ROW, 8'd0, 1'b0);
        checkOutput("row complete rise", complete, 1'b1);
        checkOutput("row Edges held", Edges, rowExp[15]);
        applyStimulus(1'b1, 1'b1, SCAN_ROW, 8'd0, 1'b0);
        checkOutput("row complete sticky", complete, 1'b1);

        // resetBuff wins over enable and clears status on the edge.
        applyStimulus(1'b1, 1'b1, SCAN_ROW, 8'd0, 1'b1);
        checkOutput("resetBuff complete", complete, 1'b0);
        checkOutput("resetBuff Edges", Edges, 1'b0);

        // Column-major feed, read back row-major.
        writeImage(stepPix, SCAN_COL);
        readRange("col", colExp, 0, 15);
        applyStimulus(1'b1, 1'b1, SCAN_ROW, 8'd0, 1'b0);
        checkOutput("col complete rise", complete, 1'b1);

        // Async reset part-way through a second read-out.
        applyStimulus(1'b1, 1'b1, SCAN_ROW, 8'd0, 1'b1);
        readRange("reread", colExp, 0, 9);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset Edges", Edges, 1'b0);
        checkOutput("async reset complete", complete, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // After reset: fresh write from pixel 0, unlisted scan code behaves as row-major.
        writeImage(stepPix, 3'b101);
        readRange("step", stepExp, 0, 15);
        applyStimulus(1'b1, 1'b1, SCAN_ROW, 8'd0, 1'b0);
        checkOutput("step complete rise", complete, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
